// File: rtl/nor_stimulus_checker.sv
// rtl/nor_stimulus_checker.sv - stimulus generator and reduction-NOR response checker for a combinational DUT
// Optional feature macro: RANDOM_PHASE_EN (adds an LFSR-driven random phase after the exhaustive sweep)
module nor_stimulus_checker #(
   parameter int          WIDTH      = 2,
   parameter int          SETTLE     = 2,
   parameter int          ERR_W      = 8,
   parameter int          RAND_COUNT = 10,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic             dut_o_i,
   output logic [WIDTH-1:0] stim_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [ERR_W-1:0] error_count_o,
   output logic             first_fail_valid_o,
   output logic [WIDTH-1:0] first_fail_stim_o
);

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   // Parameter sanity checks, evaluated at elaboration
   if (SETTLE < 1) begin : g_bad_settle
      $error("SETTLE must be >= 1");
   end
   if (LFSR_SEED == 16'h0000) begin : g_bad_seed
      $error("LFSR_SEED must be nonzero");
   end
   if (RAND_COUNT < 1) begin : g_bad_rand_count
      $error("RAND_COUNT must be >= 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   stim_q;
   logic               busy_q;
   logic               done_q;
   logic               pass_q;
   logic [ERR_W-1:0]   err_q;
   logic               ffv_q;
   logic [WIDTH-1:0]   ffs_q;

   logic               mismatch;
   logic [ERR_W-1:0]   err_d;
   logic [WIDTH-1:0]   stim_d;
   logic               last_vec;

   // Compare the sampled DUT output with the reduction-NOR model; count saturates
   assign mismatch = (dut_o_i != ~|stim_q);
   assign err_d    = (mismatch && (err_q != {ERR_W{1'b1}})) ? err_q + 1'b1 : err_q;

`ifdef RANDOM_PHASE_EN
   localparam int RC_W = $clog2(RAND_COUNT + 1);

   logic [15:0]     lfsr_q;
   logic [15:0]     lfsr_d;
   logic            rand_phase_q;
   logic [RC_W-1:0] rand_cnt_q;
   logic            rand_step;

   // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0
   assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign last_vec  = rand_phase_q && (rand_cnt_q == RC_W'(RAND_COUNT - 1));
   assign rand_step = rand_phase_q || (&stim_q);
   assign stim_d    = rand_step ? lfsr_d[WIDTH-1:0] : stim_q + 1'b1;
`else
   assign last_vec  = &stim_q;
   assign stim_d    = stim_q + 1'b1;
`endif

   // Run controller: start -> (settle, check) per vector -> done, all outputs registered
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         stim_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         ffv_q   <= 1'b0;
         ffs_q   <= '0;
`ifdef RANDOM_PHASE_EN
         lfsr_q       <= LFSR_SEED;
         rand_phase_q <= 1'b0;
         rand_cnt_q   <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  state_q <= S_WAIT;
                  cnt_q   <= '0;
                  stim_q  <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  err_q   <= '0;
                  ffv_q   <= 1'b0;
                  ffs_q   <= '0;
`ifdef RANDOM_PHASE_EN
                  lfsr_q       <= LFSR_SEED;
                  rand_phase_q <= 1'b0;
                  rand_cnt_q   <= '0;
`endif
               end
            end
            S_WAIT: begin
               if (cnt_q == CNT_W'(SETTLE - 1)) begin
                  cnt_q   <= '0;
                  state_q <= S_CHECK;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_CHECK: begin
               err_q <= err_d;
               if (mismatch && !ffv_q) begin
                  ffv_q <= 1'b1;
                  ffs_q <= stim_q;
               end
               if (last_vec) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_d == '0);
               end else begin
                  state_q <= S_WAIT;
                  stim_q  <= stim_d;
`ifdef RANDOM_PHASE_EN
                  if (rand_step) begin
                     lfsr_q       <= lfsr_d;
                     rand_phase_q <= 1'b1;
                     if (rand_phase_q) begin
                        rand_cnt_q <= rand_cnt_q + 1'b1;
                     end
                  end
`endif
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign stim_o             = stim_q;
   assign busy_o             = busy_q;
   assign done_o             = done_q;
   assign pass_o             = pass_q;
   assign error_count_o      = err_q;
   assign first_fail_valid_o = ffv_q;
   assign first_fail_stim_o  = ffs_q;

endmodule
